// File: rtl/imm_pipe.sv
// Decode-stage immediate generator: combinational RV formats into a DEPTH-entry FIFO with valid/ready on both sides.
// Define IMM_ERR_CNT_EN to add the saturating illegal-format counter on ErrCount.
module imm_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Flush,
    input  logic            InValid,
    output logic            InReady,
    input  logic [31:0]     Instr,
    input  logic [2:0]      ImmSrc,
    output logic            OutValid,
    input  logic            OutReady,
    output logic [XLEN-1:0] ImmExt,
    output logic            ImmErr,
    output logic [15:0]     ErrCount
);

    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic            err;
        logic [XLEN-1:0] imm;
    } entry_t;

    logic        s;
    logic [63:0] wide;
    entry_t      din;
    logic        unused;

    // Build every format at 64 bits and keep the low XLEN.
    always_comb begin
        s       = Instr[31];
        wide    = '0;
        din.err = 1'b0;
        case (ImmSrc)
            3'b000: wide = {{52{s}}, Instr[31:20]};
            3'b001: wide = {{52{s}}, Instr[31:25], Instr[11:7]};
            3'b010: wide = {{51{s}}, Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0};
            3'b011: wide = {{43{s}}, Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0};
            3'b100: wide = {{32{s}}, Instr[31:12], 12'b0};
            3'b101: wide = {59'b0, Instr[19:15]};
            3'b110: wide = (XLEN == 64) ? {58'b0, Instr[25:20]} : {59'b0, Instr[24:20]};
            default: begin
                wide    = 64'h0000_0000_0000_DEAD;
                din.err = 1'b1;
            end
        endcase
        din.imm = wide[XLEN-1:0];
    end

    assign unused = ^{Instr[6:0], wide};

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   cnt;
    logic          push, pop;

    assign InReady  = (cnt != FULL);
    assign OutValid = (cnt != '0);
    assign push     = InValid && InReady && !Flush;
    assign pop      = OutValid && OutReady && !Flush;

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (Flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Outputs read zero while empty so stale storage never leaks out.
    assign head   = mem[rptr];
    assign ImmExt = OutValid ? head.imm : '0;
    assign ImmErr = OutValid ? head.err : 1'b0;

`ifdef IMM_ERR_CNT_EN
    logic [15:0] err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_cnt <= '0;
        else if (push && din.err && err_cnt != 16'hFFFF)
            err_cnt <= err_cnt + 16'd1;
    end

    assign ErrCount = err_cnt;
`else
    assign ErrCount = 16'h0000;
`endif

endmodule

// File: tb/tb_imm_pipe.sv
// Scoreboard bench for imm_pipe: XLEN=32 and XLEN=64 instances share stimulus, each with its own expected queue.
module tb_imm_pipe;

`ifdef IMM_ERR_CNT_EN
    localparam logic [15:0] EXP_CNT = 16'd3;
`else
    localparam logic [15:0] EXP_CNT = 16'd0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] instr;
    logic [2:0]  imm_src;

    logic        ir32, ov32, err32, ir64, ov64, err64;
    logic [31:0] ext32;
    logic [63:0] ext64;
    logic [15:0] cnt32, cnt64;

    int nchk = 0;
    int nerr = 0;

    logic [64:0] q32[$];
    logic [64:0] q64[$];

    always #5 clk = ~clk;

    imm_pipe #(.XLEN(32), .DEPTH(2)) d32 (
        .clk(clk), .rst(rst), .Flush(flush), .InValid(in_valid), .InReady(ir32),
        .Instr(instr), .ImmSrc(imm_src), .OutValid(ov32), .OutReady(out_ready),
        .ImmExt(ext32), .ImmErr(err32), .ErrCount(cnt32)
    );

    imm_pipe #(.XLEN(64), .DEPTH(2)) d64 (
        .clk(clk), .rst(rst), .Flush(flush), .InValid(in_valid), .InReady(ir64),
        .Instr(instr), .ImmSrc(imm_src), .OutValid(ov64), .OutReady(out_ready),
        .ImmExt(ext64), .ImmErr(err64), .ErrCount(cnt64)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: extract the raw field, then sign-fill above its width.
    function automatic logic [64:0] model(input logic [31:0] i, input logic [2:0] src, input int xlen);
        logic [63:0] raw;
        int          wd;
        logic        sx, err;
        raw = '0; wd = 64; sx = 1'b0; err = 1'b0;
        case (src)
            3'd0: begin raw = 64'(i[31:20]); wd = 12; sx = 1'b1; end
            3'd1: begin raw = 64'({i[31:25], i[11:7]}); wd = 12; sx = 1'b1; end
            3'd2: begin raw = 64'({i[31], i[7], i[30:25], i[11:8], 1'b0}); wd = 13; sx = 1'b1; end
            3'd3: begin raw = 64'({i[31], i[19:12], i[20], i[30:21], 1'b0}); wd = 21; sx = 1'b1; end
            3'd4: begin raw = 64'({i[31:12], 12'b0}); wd = 32; sx = 1'b1; end
            3'd5: raw = 64'(i[19:15]);
            3'd6: raw = (xlen == 64) ? 64'(i[25:20]) : 64'(i[24:20]);
            default: begin raw = 64'hDEAD; err = 1'b1; end
        endcase
        if (sx && i[31]) raw = raw | ~((64'd1 << wd) - 64'd1);
        if (xlen == 32) raw[63:32] = '0;
        return {err, raw};
    endfunction

    // Scoreboard: pops compared against the head, accepted pushes queued, flush drops everything.
    always @(negedge clk) begin
        logic [64:0] e;
        if (!rst) begin
            if (flush) begin
                q32.delete();
                q64.delete();
            end else begin
                if (ov32 && out_ready) begin
                    chk("sb32_nonempty", 64'(q32.size() != 0), 64'd1);
                    if (q32.size() != 0) begin
                        e = q32.pop_front();
                        chk("sb32_imm", 64'(ext32), e[63:0]);
                        chk("sb32_err", 64'(err32), 64'(e[64]));
                    end
                end
                if (ov64 && out_ready) begin
                    chk("sb64_nonempty", 64'(q64.size() != 0), 64'd1);
                    if (q64.size() != 0) begin
                        e = q64.pop_front();
                        chk("sb64_imm", ext64, e[63:0]);
                        chk("sb64_err", 64'(err64), 64'(e[64]));
                    end
                end
                if (in_valid && ir32) q32.push_back(model(instr, imm_src, 32));
                if (in_valid && ir64) q64.push_back(model(instr, imm_src, 64));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; imm_src = '0;
        step(); step();
        chk("rst_inready", 64'(ir32), 64'd1);
        chk("rst_outvalid", 64'(ov32), 64'd0);
        chk("rst_immext", 64'(ext32), 64'd0);
        chk("rst_immerr", 64'(err32), 64'd0);
        chk("rst_errcount", 64'(cnt32), 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        step();

        // Directed formats; each entry pops one edge after it appears.
        in_valid = 1'b1; instr = 32'hFFF00093; imm_src = 3'd0; step(); in_valid = 1'b0;
        chk("i_outvalid", 64'(ov32), 64'd1);
        chk("i_imm32", 64'(ext32), 64'hFFFFFFFF);
        chk("i_err32", 64'(err32), 64'd0);
        step();
        in_valid = 1'b1; instr = 32'h800000B7; imm_src = 3'd4; step(); in_valid = 1'b0;
        chk("u_neg_imm64", ext64, 64'hFFFFFFFF80000000);
        chk("u_neg_imm32", 64'(ext32), 64'h80000000);
        step();
        in_valid = 1'b1; instr = 32'h123450B7; imm_src = 3'd4; step(); in_valid = 1'b0;
        chk("u_pos_imm64", ext64, 64'h0000000012345000);
        step();
        in_valid = 1'b1; instr = 32'hFE000EE3; imm_src = 3'd2; step(); in_valid = 1'b0;
        chk("b_imm32", 64'(ext32), 64'hFFFFFFFC);
        step();
        in_valid = 1'b1; instr = 32'h000FD073; imm_src = 3'd5; step(); in_valid = 1'b0;
        chk("z_imm32", 64'(ext32), 64'h1F);
        step();
        in_valid = 1'b1; instr = 32'h41F0D093; imm_src = 3'd6; step(); in_valid = 1'b0;
        chk("sh_imm32", 64'(ext32), 64'h1F);
        step();
        in_valid = 1'b1; instr = 32'h43F0D093; imm_src = 3'd6; step(); in_valid = 1'b0;
        chk("sh_imm64", ext64, 64'h3F);
        chk("sh_imm32_5bit", 64'(ext32), 64'h1F);
        step();

        // Backpressure: fill, try a blocked push, then pop one.
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h00100093; imm_src = 3'd0; step();
        instr = 32'h00200093; step();
        chk("bp_full_inready", 64'(ir32), 64'd0);
        chk("bp_full_outvalid", 64'(ov32), 64'd1);
        chk("bp_head", 64'(ext32), 64'd1);
        instr = 32'h00300093; step();
        chk("bp_head_stable", 64'(ext32), 64'd1);
        chk("bp_still_full", 64'(ir32), 64'd0);
        out_ready = 1'b1; step();
        in_valid = 1'b0;
        chk("bp_inready_after_pop", 64'(ir32), 64'd1);
        chk("bp_second_head", 64'(ext32), 64'd2);
        step();
        chk("bp_drained", 64'(ov32), 64'd0);

        // Sustained throughput with random legal formats.
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            instr = $urandom; imm_src = 3'($urandom_range(0, 6));
            step();
            chk("tp_inready", 64'(ir32), 64'd1);
        end
        in_valid = 1'b0;
        step();
        chk("tp_empty", 64'(ov32), 64'd0);
        chk("tp_sb_empty", 64'(q32.size() + q64.size()), 64'd0);

        // Illegal format three times.
        in_valid = 1'b1; instr = 32'h12345678; imm_src = 3'd7; step();
        chk("ill_imm32", 64'(ext32), 64'hDEAD);
        chk("ill_imm64", ext64, 64'h000000000000DEAD);
        chk("ill_err", 64'(err32), 64'd1);
        step(); step();
        in_valid = 1'b0; step();
        chk("ill_cnt32", 64'(cnt32), 64'(EXP_CNT));
        chk("ill_cnt64", 64'(cnt64), 64'(EXP_CNT));

        // Flush a full FIFO while also presenting input.
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h00500093; imm_src = 3'd0; step();
        instr = 32'h00600093; step();
        flush = 1'b1; instr = 32'h00700093; step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_outvalid", 64'(ov32), 64'd0);
        chk("fl_outvalid64", 64'(ov64), 64'd0);
        chk("fl_inready", 64'(ir32), 64'd1);
        chk("fl_immext", 64'(ext32), 64'd0);
        step();
        chk("fl_input_lost", 64'(ov32), 64'd0);
        chk("fl_cnt_kept", 64'(cnt32), 64'(EXP_CNT));

        // Asynchronous reset mid-stream.
        in_valid = 1'b1; instr = 32'hFFF00093; imm_src = 3'd0; step();
        instr = 32'h00800093; step();
        in_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("ar_inready", 64'(ir32), 64'd1);
        chk("ar_outvalid", 64'(ov32), 64'd0);
        chk("ar_immext64", ext64, 64'd0);
        chk("ar_immerr", 64'(err32), 64'd0);
        chk("ar_errcount", 64'(cnt32), 64'd0);
        q32.delete(); q64.delete();
        step();
        rst = 1'b0;
        step();
        chk("ar_no_stale", 64'(ov32), 64'd0);
        out_ready = 1'b1;
        in_valid = 1'b1; instr = 32'h00900093; imm_src = 3'd0; step(); in_valid = 1'b0;
        chk("ar_fresh_entry", 64'(ext32), 64'd9);
        step(); step();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
